// File: rtl/latch_bank_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : latch_bank_arbiter
// Description : Round-robin arbiter that sequences writes from two requesters
//               into a bank of four D latches using setup/gate/hold timing.
// Revision    : 1.0 - initial release
// ============================================================================

module latch_bank_arbiter #(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        addr0,
    input  logic [1:0]        addr1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] lat_d,
    output logic [3:0]        lat_en,
    output logic              busy
);

    localparam int c_MAX_SG  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int c_MAX_CYC = (c_MAX_SG > HOLD_CYC) ? c_MAX_SG : HOLD_CYC;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GATE_LD  = c_CNT_W'(GATE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_GATE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                winner_q, winner_d;
    logic [1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   lat_d_q, lat_d_d;
    logic                ptr_q, ptr_d;

    logic                w_win;
    logic                w_first_setup;
    logic                w_last_hold;

    // With both requesting the pointer decides; otherwise the sole requester wins.
    assign w_win = (req0 && req1) ? ptr_q : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            winner_q <= 1'b0;
            addr_q   <= 2'd0;
            lat_d_q  <= '0;
            ptr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            lat_d_q  <= lat_d_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        lat_d_d  = lat_d_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    winner_d = w_win;
                    addr_d   = w_win ? addr1 : addr0;
                    lat_d_d  = w_win ? din1 : din0;
                    cnt_d    = c_SETUP_LD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = c_GATE_LD;
                    state_d = ST_GATE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    cnt_d   = c_HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    ptr_d   = ~winner_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the async-reset state directly, so reset clears them at once.
    assign w_first_setup = (state_q == ST_SETUP) && (cnt_q == c_SETUP_LD);
    assign w_last_hold   = (state_q == ST_HOLD) && (cnt_q == '0);

    assign gnt0   = w_first_setup && !winner_q;
    assign gnt1   = w_first_setup &&  winner_q;
    assign done0  = w_last_hold && !winner_q;
    assign done1  = w_last_hold &&  winner_q;
    assign busy   = (state_q != ST_IDLE);
    assign lat_d  = lat_d_q;
    assign lat_en = (state_q == ST_GATE) ? (4'b0001 << addr_q) : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_latch_bank_arbiter
// Description : Directed and randomized checks of latch_bank_arbiter against
//               a transaction-level timeline model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_latch_bank_arbiter;

    localparam int c_S = 1;
    localparam int c_G = 2;
    localparam int c_H = 1;
    localparam int c_T = c_S + c_G + c_H;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] addr0, addr1;
    logic [7:0] din0, din1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] lat_d;
    logic [3:0] lat_en;

    int checks;
    int errors;

    latch_bank_arbiter #(
        .DATA_W    (8),
        .SETUP_CYC (c_S),
        .GATE_CYC  (c_G),
        .HOLD_CYC  (c_H)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .addr0  (addr0),
        .addr1  (addr1),
        .din0   (din0),
        .din1   (din1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .lat_d  (lat_d),
        .lat_en (lat_en),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a transaction is a timeline t = 1..c_T after its grant edge.
    logic       m_active;
    int         m_t;
    logic       m_win;
    logic [1:0] m_addr;
    logic [7:0] m_lat_d;
    logic       m_ptr;
    logic       m_pick;

    assign m_pick = (req0 && req1) ? m_ptr : req1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_win    <= 1'b0;
            m_addr   <= 2'd0;
            m_lat_d  <= 8'h00;
            m_ptr    <= 1'b0;
        end else if (!m_active) begin
            if (req0 || req1) begin
                m_active <= 1'b1;
                m_t      <= 1;
                m_win    <= m_pick;
                m_addr   <= m_pick ? addr1 : addr0;
                m_lat_d  <= m_pick ? din1 : din0;
            end
        end else if (m_t == c_T) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_ptr    <= !m_win;
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic       e_gnt0, e_gnt1, e_done0, e_done1, e_busy;
    logic [3:0] e_lat_en;
    logic [16:0] exp_vec;

    assign e_busy   = m_active;
    assign e_gnt0   = m_active && (m_t == 1) && !m_win;
    assign e_gnt1   = m_active && (m_t == 1) &&  m_win;
    assign e_done0  = m_active && (m_t == c_T) && !m_win;
    assign e_done1  = m_active && (m_t == c_T) &&  m_win;
    assign e_lat_en = (m_active && (m_t > c_S) && (m_t <= c_S + c_G)) ? 4'(1 << m_addr) : 4'h0;
    assign exp_vec  = {e_gnt0, e_gnt1, e_done0, e_done1, e_busy, e_lat_en, m_lat_d};

    function automatic logic [16:0] obs_vec();
        return {gnt0, gnt1, done0, done1, busy, lat_en, lat_d};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 2'd0; addr1 = 2'd0;
        din0 = 8'h00; din1 = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req0 = 1'($urandom); req1 = 1'($urandom);
        addr0 = 2'($urandom); addr1 = 2'($urandom);
        din0 = 8'($urandom); din1 = 8'($urandom);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 17'h0) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", obs_vec(), 17'h0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req0 = 1'($urandom); req1 = 1'($urandom);
            din0 = 8'($urandom); din1 = 8'($urandom);
            #1;
            checks++;
            if (obs_vec() !== 17'h0) begin
                errors++;
                $display("FAIL reset_held c=%0d got=%h exp=%h", c, obs_vec(), 17'h0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== 17'h0) begin
                errors++;
                $display("FAIL reset_release_idle c=%0d got=%h exp=%h", c, obs_vec(), 17'h0);
            end
        end
    endtask

    task automatic test_single_write();
        logic [16:0] exp;
        do_reset();
        req0 = 1'b1; addr0 = 2'd2; din0 = 8'hA5;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp = {c == 1, 1'b0, c == 4, 1'b0, c <= 4,
                   (c == 2 || c == 3) ? 4'b0100 : 4'b0000, 8'hA5};
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL single_write cycle=%0d got=%h exp=%h", c, obs_vec(), exp);
            end
            if (c == 4) req0 = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic [16:0] exp;
        do_reset();
        req0 = 1'b1; addr0 = 2'd0; din0 = 8'h11;
        req1 = 1'b1; addr1 = 2'd3; din1 = 8'h22;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp = {c == 1, c == 6, c == 4, c == 9, c != 5,
                   (c == 2 || c == 3) ? 4'b0001 : ((c == 7 || c == 8) ? 4'b1000 : 4'b0000),
                   (c <= 5) ? 8'h11 : 8'h22};
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL contention cycle=%0d got=%h exp=%h", c, obs_vec(), exp);
            end
            if (c == 4) req0 = 1'b0;
            if (c == 9) req1 = 1'b0;
        end
    endtask

    task automatic test_fairness();
        int ngrant = 0;
        int ndone  = 0;
        do_reset();
        req0 = 1'b1; addr0 = 2'd1; din0 = 8'h0F;
        req1 = 1'b1; addr1 = 2'd2; din1 = 8'hF0;
        for (int c = 0; c < 40 && ndone < 6; c++) begin
            @(negedge clk);
            checks++;
            if (!$onehot0(lat_en) || (gnt0 && gnt1) || (done0 && done1)) begin
                errors++;
                $display("FAIL fairness_exclusive cycle=%0d lat_en=%b gnt=%b%b done=%b%b",
                         c, lat_en, gnt0, gnt1, done0, done1);
            end
            if (gnt0 || gnt1) begin
                checks++;
                if (gnt1 !== 1'(ngrant % 2)) begin
                    errors++;
                    $display("FAIL fairness_order grant#%0d got_gnt1=%b exp_gnt1=%0d",
                             ngrant, gnt1, ngrant % 2);
                end
                ngrant++;
            end
            if (done0 || done1) ndone++;
            if (ndone == 6) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (ngrant != 6 || ndone != 6) begin
            errors++;
            $display("FAIL fairness_count got grants=%0d dones=%0d exp 6/6", ngrant, ndone);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fairness_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_data_stability();
        logic [16:0] exp;
        do_reset();
        req0 = 1'b1; addr0 = 2'd1; din0 = 8'h3C;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp = {c == 1, 1'b0, c == 4, 1'b0, 1'b1,
                   (c == 2 || c == 3) ? 4'b0010 : 4'b0000, 8'h3C};
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL data_stability cycle=%0d got=%h exp=%h", c, obs_vec(), exp);
            end
            if (c == 2) begin
                din0  = 8'hFF;
                addr0 = 2'd3;
            end
            if (c == 4) req0 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_gate();
        logic [16:0] exp;
        do_reset();
        req0 = 1'b1; addr0 = 2'd2; din0 = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (lat_en !== 4'b0100) begin
            errors++;
            $display("FAIL mid_gate_open lat_en got=%b exp=0100", lat_en);
        end
        req1 = 1'b1; addr1 = 2'd1; din1 = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 17'h0) begin
            errors++;
            $display("FAIL mid_gate_reset got=%h exp=%h", obs_vec(), 17'h0);
        end
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp = {1'b0, c == 1, 1'b0, c == 4, c <= 4,
                   (c == 2 || c == 3) ? 4'b0010 : 4'b0000, 8'h77};
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL mid_gate_recover cycle=%0d got=%h exp=%h", c, obs_vec(), exp);
            end
            if (c == 4) req1 = 1'b0;
        end
    endtask

    task automatic test_random();
        logic pend0 = 1'b0, pend1 = 1'b0;
        logic gone0 = 1'b0, gone1 = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
            end
            if (e_done0) begin
                pend0 = 1'b0; gone0 = 1'b0; req0 = 1'b0;
            end else if (e_gnt0) begin
                gone0 = 1'b1;
            end
            if (e_done1) begin
                pend1 = 1'b0; gone1 = 1'b0; req1 = 1'b0;
            end else if (e_gnt1) begin
                gone1 = 1'b1;
            end
            if (!pend0 && !e_done0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1'b1; req0 = 1'b1;
                addr0 = 2'($urandom); din0 = 8'($urandom);
            end else if (gone0) begin
                din0 = 8'($urandom); addr0 = 2'($urandom);
                if (req0 && $urandom_range(0, 4) == 0) req0 = 1'b0;
            end
            if (!pend1 && !e_done1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1'b1; req1 = 1'b1;
                addr1 = 2'($urandom); din1 = 8'($urandom);
            end else if (gone1) begin
                din1 = 8'($urandom); addr1 = 2'($urandom);
                if (req1 && $urandom_range(0, 4) == 0) req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 2'd0; addr1 = 2'd0;
        din0 = 8'h00; din1 = 8'h00;
        test_reset();
        test_single_write();
        test_contention();
        test_fairness();
        test_data_stability();
        test_reset_mid_gate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/latch_bank_arbiter.md
LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

Interface
REQ-001 Parameter DATA_W, 8, width of the data word written into each latch entry.
REQ-002 Parameter SETUP_CYC, 1, number of cycles lat_d is stable before the gate opens (>=1).
REQ-003 Parameter GATE_CYC, 2, number of cycles the selected lat_en is high (>=1).
REQ-004 Parameter HOLD_CYC, 1, number of cycles lat_d is held after the gate closes (>=1).
REQ-005 The block SHALL have one clock and an asynchronous active-low reset.
REQ-006 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 req0 / req1  input  1 each  write request from requester 0 / 1; held high until the matching done.
REQ-009 addr0 / addr1  input  2 each  target latch entry (0-3) for requester 0 / 1.
REQ-010 din0 / din1  input  DATA_W each  write data for requester 0 / 1.
REQ-011 gnt0 / gnt1  output  1 each  one-cycle grant pulse.
REQ-012 done0 / done1  output  1 each  one-cycle completion pulse.
REQ-013 lat_d  output  DATA_W  shared D bus driven to all four latch entries.
REQ-014 lat_en  output  4  per-entry latch gate (CLK input of each D latch); one-hot or zero.
REQ-015 busy  output  1  high while a transaction occupies the bank.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, GATE and HOLD.
REQ-017 In IDLE with at least one req high, the arbiter SHALL select a winner, capture its addr and din into internal registers and lat_d, and enter SETUP on the next edge.
REQ-018 Arbitration SHALL be round-robin: with a single request, that requester wins; with both requests, the requester named by the priority pointer wins.
REQ-019 After each completed transaction, the priority pointer SHALL point to the requester that did not win.
REQ-020 gntX SHALL be high only in the first SETUP cycle of transaction X.
REQ-021 SETUP SHALL last SETUP_CYC cycles, GATE GATE_CYC cycles and HOLD HOLD_CYC cycles, counted by a single down-counter reloaded on each state entry.
REQ-022 lat_en[captured addr] SHALL be high only during GATE; all other lat_en bits SHALL be 0; lat_en SHALL be 4'b0000 in every other state.
REQ-023 lat_d SHALL be constant from the first SETUP cycle through the last HOLD cycle, regardless of changes on din/addr inputs.
REQ-024 doneX SHALL be high in the last HOLD cycle only; the FSM then returns to IDLE.
REQ-025 An IDLE cycle SHALL always separate transactions, so the maximum rate is one write per SETUP_CYC+GATE_CYC+HOLD_CYC+1 cycles.
REQ-026 busy SHALL be high in SETUP, GATE and HOLD, and low in IDLE.
REQ-027 If reqX deasserts mid-transaction, the transaction SHALL still complete including doneX; a request is never aborted except by reset.
REQ-028 In IDLE, lat_d SHALL keep its last value, avoiding needless toggling of the bus.
REQ-029 gnt0 and gnt1 SHALL never be high together, and done0 and done1 SHALL never be high together.

Reset
REQ-030 While RST_N=0, the block SHALL immediately (asynchronously) force: state=IDLE, pointer=requester 0, lat_en=0, lat_d=0, gnt0=gnt1=0, done0=done1=0, busy=0.
REQ-031 A reset asserted mid-transaction SHALL close the gate at once; no done SHALL be issued for the aborted write.
REQ-032 After RST_N rises, the first arbitration SHALL occur on the first rising edge of CLK with a req high.

Verification (defaults S=1, G=2, H=1; cycle 1 = first cycle after the grant edge)
REQ-033 Reset: RST_N=0 with random inputs -> all outputs 0 at once; after release, busy=0 until a req arrives.
REQ-034 Single write: req0=1, addr0=2, din0=8'hA5 -> gnt0 and lat_d=8'hA5 in cycle 1; lat_en=4'b0100 in cycles 2-3; done0 in cycle 4; busy high in cycles 1-4; lat_en=0 in cycles 1 and 4.
REQ-035 Contention after reset: req0 and req1 rise together (addr0=0, addr1=3) -> requester 0 is served first (gnt0 in cycle 1); gnt1 in cycle 6; lat_en=4'b1000 in cycles 7-8; done1 in cycle 9.
REQ-036 Fairness: req0 and req1 held high continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; lat_en is never multi-hot.
REQ-037 Data stability: din0 changes from 8'h3C to 8'hFF in cycle 2 of a transaction -> lat_d stays 8'h3C through cycle 4.
REQ-038 Reset mid-gate: RST_N=0 during cycle 2 -> lat_en=0 immediately and no done0; after release with req1 only pending -> gnt1 follows normally.
